// File: rtl/bp_update_arbiter_pkg.sv
// Shared types and constants for the branch-predictor update arbiter.
// Holds the FSM encoding and the layout of a buffered update entry.
package bp_update_arbiter_pkg;

    typedef enum logic [1:0] {
        BPA_INIT  = 2'd0,
        BPA_CLEAR = 2'd1,
        BPA_RUN   = 2'd2
    } bpa_state_e;

    localparam int BHT_INDEX_W = 5;
    localparam int BPA_ENTRY_W = 67;

    // Field order fixes the bit positions: direct[66] cond[65] taken[64] pc[63:32] target[31:0]
    typedef struct packed {
        logic        direct;
        logic        cond;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } bpa_entry_t;

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Bundle of the update, lookup and table-write signals around the arbiter.
// The slave side is the arbiter; the master side is its environment.
interface bp_update_arbiter_if #(
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) ();
    logic             upd_valid;
    logic             upd_direct;
    logic             upd_cond;
    logic             upd_taken;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             lookup_req;
    logic             clear_req;
    logic             wr_valid;
    logic             wr_clear;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_direct;
    logic             wr_cond;
    logic             wr_taken;
    logic [31:0]      wr_pc;
    logic [31:0]      wr_target;
    logic             lookup_stall;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output upd_valid, upd_direct, upd_cond, upd_taken, upd_pc, upd_target,
        output lookup_req, clear_req,
        input  wr_valid, wr_clear, wr_idx, wr_direct, wr_cond, wr_taken,
        input  wr_pc, wr_target, lookup_stall, busy, drop_cnt
    );

    modport slave (
        input  upd_valid, upd_direct, upd_cond, upd_taken, upd_pc, upd_target,
        input  lookup_req, clear_req,
        output wr_valid, wr_clear, wr_idx, wr_direct, wr_cond, wr_taken,
        output wr_pc, wr_target, lookup_stall, busy, drop_cnt
    );
endinterface

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO for resolved-branch updates with extra-bit full/empty pointers.
// The head is read combinationally and reads as zero while empty; flush beats push/pop.
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 67
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/bp_update_arbiter.sv
// Arbitrates the shared predictor-table port between lookups and buffered updates,
// and sweeps every table index with clear writes after reset or on request.
module bp_update_arbiter
    import bp_update_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = BHT_INDEX_W,
    parameter int STARVE_LIM = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    bp_update_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [IDX_W-1:0] IDX_MAX    = '1;
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    bpa_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx, w_clr_idx_nxt;
    logic [SW-1:0]    r_starve, w_starve_nxt;
    logic [CNT_W-1:0] r_drop, w_drop_nxt;
    logic             w_eligible, w_grant, w_push, w_flush, w_empty, w_full;
    bpa_entry_t       w_upd_entry, w_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign w_eligible  = bus.upd_valid && (bus.upd_direct || bus.upd_cond);
    assign w_upd_entry = '{direct: bus.upd_direct, cond: bus.upd_cond, taken: bus.upd_taken,
                           pc: bus.upd_pc, target: bus.upd_target};

    bp_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BPA_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_grant),
        .i_flush (w_flush),
        .i_din   (w_upd_entry),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= BPA_INIT;
            r_clr_idx <= '0;
            r_starve  <= '0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_starve  <= w_starve_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_idx_nxt    = '0;
        w_starve_nxt     = '0;
        w_drop_nxt       = r_drop;
        w_grant          = 1'b0;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        bus.wr_valid     = 1'b0;
        bus.wr_clear     = 1'b0;
        bus.wr_idx       = '0;
        bus.wr_direct    = 1'b0;
        bus.wr_cond      = 1'b0;
        bus.wr_taken     = 1'b0;
        bus.wr_pc        = '0;
        bus.wr_target    = '0;
        bus.lookup_stall = 1'b0;
        bus.busy         = 1'b0;

        case (r_state)
            BPA_INIT: begin
                bus.busy         = 1'b1;
                bus.lookup_stall = 1'b1;
                w_flush          = 1'b1;
                w_state_nxt      = BPA_CLEAR;
            end
            BPA_CLEAR: begin
                bus.busy         = 1'b1;
                bus.wr_valid     = 1'b1;
                bus.wr_clear     = 1'b1;
                bus.wr_idx       = r_clr_idx;
                bus.lookup_stall = bus.lookup_req;
                w_flush          = 1'b1;
                if (bus.clear_req) begin
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
                    if (r_clr_idx == IDX_MAX) w_state_nxt = BPA_RUN;
                end
            end
            BPA_RUN: begin
                // A lookup only loses the port once the head has waited STARVE_LIM cycles
                w_grant = !w_empty && (!bus.lookup_req || (r_starve == STARVE_MAX));
                if (w_grant) begin
                    bus.wr_valid     = 1'b1;
                    bus.wr_direct    = w_head.direct;
                    bus.wr_cond      = w_head.cond;
                    bus.wr_taken     = w_head.taken;
                    bus.wr_pc        = w_head.pc;
                    bus.wr_target    = w_head.target;
                    bus.lookup_stall = bus.lookup_req;
                end
                if (bus.clear_req) begin
                    w_state_nxt = BPA_CLEAR;
                    w_flush     = 1'b1;
                end else begin
                    if (w_eligible) begin
                        if (!w_full || w_grant) w_push = 1'b1;
                        else                    w_drop_nxt = sat_inc(r_drop);
                    end
                    if (!w_grant && !w_empty && bus.lookup_req)
                        w_starve_nxt = r_starve + SW'(1);
                end
            end
            default: w_state_nxt = BPA_INIT;
        endcase
    end

    assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Randomized and directed bench for bp_update_arbiter against a queue-based model.
// The model tracks phase, sweep index, pending updates, starvation age and drop count.
module tb_bp_update_arbiter;
    localparam int DEPTH = 4;
    localparam int IDXW  = 5;
    localparam int LIM   = 3;
    localparam int CW    = 3;
    localparam int NIDX  = 1 << IDXW;
    localparam int DMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic        d;
        logic        c;
        logic        t;
        logic [31:0] pc;
        logic [31:0] tg;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bp_update_arbiter_if #(.IDX_W(IDXW), .CNT_W(CW)) bus ();

    bp_update_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .IDX_W      (IDXW),
        .STARVE_LIM (LIM),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_phase;   // 0 = INIT, 1 = CLEAR, 2 = RUN
    int   m_idx;
    int   m_starve;
    int   m_drop;
    ent_t m_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_idx    = 0;
        m_starve = 0;
        m_drop   = 0;
        m_q.delete();
    endtask

    task automatic cyc(input logic v, input logic d, input logic c, input logic t,
                       input logic [31:0] pc, input logic [31:0] tg,
                       input logic lk, input logic cl);
        bit   grant;
        bit   elig;
        ent_t e;
        @(negedge clk);
        bus.upd_valid  = v;
        bus.upd_direct = d;
        bus.upd_cond   = c;
        bus.upd_taken  = t;
        bus.upd_pc     = pc;
        bus.upd_target = tg;
        bus.lookup_req = lk;
        bus.clear_req  = cl;
        #1;
        grant = (m_phase == 2) && (m_q.size() > 0) && (!lk || m_starve == LIM);
        case (m_phase)
            0: begin
                chk("ctrl_init", {bus.wr_valid, bus.wr_clear, bus.busy, bus.lookup_stall}, 4'b0011);
                chk("head_init", {bus.wr_direct, bus.wr_cond, bus.wr_taken, bus.wr_pc, bus.wr_target}, 67'd0);
            end
            1: begin
                chk("ctrl_clear", {bus.wr_valid, bus.wr_clear, bus.busy, bus.lookup_stall}, {3'b111, lk});
                chk("idx_clear", bus.wr_idx, m_idx);
            end
            default: begin
                chk("ctrl_run", {bus.wr_valid, bus.wr_clear, bus.busy, bus.lookup_stall},
                    {grant, 2'b00, lk && grant});
                chk("idx_run", bus.wr_idx, 0);
                if (grant)
                    chk("head_run", {bus.wr_direct, bus.wr_cond, bus.wr_taken, bus.wr_pc, bus.wr_target},
                        m_q[0]);
            end
        endcase
        chk("drop", bus.drop_cnt, m_drop);
        @(posedge clk);
        if (rstn) begin
            elig = v && (d || c);
            e    = '{d: d, c: c, t: t, pc: pc, tg: tg};
            case (m_phase)
                0: begin
                    m_phase = 1;
                    m_idx   = 0;
                end
                1: begin
                    if (cl) m_idx = 0;
                    else if (m_idx == NIDX - 1) begin
                        m_phase = 2;
                        m_idx   = 0;
                    end else m_idx++;
                end
                default: begin
                    if (cl) begin
                        m_phase  = 1;
                        m_idx    = 0;
                        m_starve = 0;
                        m_q.delete();
                    end else begin
                        if (grant || m_q.size() == 0) m_starve = 0;
                        else if (lk)                  m_starve++;
                        if (grant) void'(m_q.pop_front());
                        if (elig) begin
                            if (m_q.size() < DEPTH) m_q.push_back(e);
                            else if (m_drop < DMAX) m_drop++;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic idle(input int n, input logic lk);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, lk, 1'b0);
    endtask

    task automatic rand_cyc(input int lk_pct, input int clr_pct);
        cyc($urandom_range(0, 99) < 60, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
            1'(($urandom_range(0, 1))), $urandom, $urandom,
            $urandom_range(0, 99) < lk_pct, $urandom_range(0, 999) < clr_pct);
    endtask

    task automatic release_reset();
        #2 rstn = 1'b1;
    endtask

    initial begin
        int lk_pct;
        bus.upd_valid  = 1'b0;
        bus.upd_direct = 1'b0;
        bus.upd_cond   = 1'b0;
        bus.upd_taken  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.lookup_req = 1'b0;
        bus.clear_req  = 1'b0;
        model_reset();

        // Held in reset with traffic on the inputs
        for (int i = 0; i < 3; i++) rand_cyc(50, 0);
        release_reset();

        // INIT, full sweep, then quiet RUN
        idle(1 + NIDX + 4, 1'b1);

        // Single direct update with the port free
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h1C00_0040, 32'h1C00_0100, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Starvation: one update while lookups hold the port
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h1C00_0080, 32'h1C00_0200, 1'b1, 1'b0);
        idle(6, 1'b1);
        idle(2, 1'b0);

        // Overflow: seven conditional updates under continuous lookups
        for (int i = 0; i < 7; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'(i), 32'h2000_0000 + i * 4, 32'h3000_0000 + i * 16, 1'b1, 1'b0);
        #3 chk("ovf_drop", bus.drop_cnt, 2);
        idle(6, 1'b0);

        // Full FIFO with a push and pop in the same cycle
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0000 + i * 4, 32'h5000_0000 + i, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_00F0, 32'h5000_00F0, 1'b0, 1'b0);
        idle(6, 1'b0);

        // Mid-run clear with queued entries, then a restart at index 10
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h6000_0000 + i * 4, 32'h7000_0000 + i, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h6000_00F0, 32'h7000_00F0, 1'b1, 1'b1);
        idle(10, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(NIDX + 4, 1'b0);

        // Random traffic with shifting lookup pressure and an asynchronous reset midway
        lk_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lk_pct = $urandom_range(0, 100);
            if (i == 1500) begin
                #2 rstn = 1'b0;
                model_reset();
                for (int k = 0; k < 2; k++) rand_cyc(lk_pct, 5);
                release_reset();
            end
            rand_cyc(lk_pct, 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
